mem_port_arbiter: RTL

- Round-robin arbiter and sequencer for the shared 32-bit memory request port.
- Grants one of four requesters (0 = instruction fetch, 1 = load/store, 2 = debug, 3 = DMA) at a time.
- Drives the 2-bit select of the mux4x32 instances that steer address and write data onto the port.
- Tracks the single outstanding transaction and routes its completion back to the owner.

---
 rtl/mem_port_arbiter_if.sv | 26 ++
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the memory-port arbiter, its four requesters
// and the shared memory request port.
interface mem_port_arbiter_if;
    logic [3:0] req_i;
    logic [3:0] lock_i;
    logic [3:0] gnt_o;
    logic [1:0] sel_o;
    logic       mem_valid_o;
    logic       mem_ready_i;
    logic       mem_rvalid_i;
    logic [3:0] ack_o;
    logic       err_o;
    logic       busy_o;

    // Requesters and memory side: drive requests and memory handshakes.
    modport master (
        output req_i, lock_i, mem_ready_i, mem_rvalid_i,
        input  gnt_o, sel_o, mem_valid_o, ack_o, err_o, busy_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, lock_i, mem_ready_i, mem_rvalid_i,
        output gnt_o, sel_o, mem_valid_o, ack_o, err_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared 32-bit memory request port.
// Grants one of four requesters, drives the mux select, tracks the single
// outstanding transaction and returns its completion (or timeout) to the owner.
module mem_port_arbiter #(
    parameter int LOCK_MAX = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_LIM = LOCK_MAX[3:0];
    localparam logic [7:0] TO_LIM   = TIMEOUT[7:0];
    localparam logic       TO_EN    = (TIMEOUT != 0);

    state_t     state_r, state_s;
    logic [1:0] sel_r, sel_s;
    logic [1:0] ptr_r, ptr_s;
    logic [3:0] lock_cnt_r, lock_cnt_s;
    logic [7:0] to_cnt_r, to_cnt_s;
    logic [2:0] pick_s;
    logic       timeout_s;
    logic       done_s;
    logic       keep_s;

    logic [3:0] gnt_s;
    logic       mem_valid_s;
    logic [3:0] ack_s;
    logic       err_s;
    logic       busy_s;

    // One-hot decode of an owner index.
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        logic [3:0] res;
        res = 4'b0001 << idx;
        return res;
    endfunction

    // First set candidate scanning start, start+1, ... mod 4; returns {found, index}.
    // Scanning from the far end down lets the nearest candidate overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // A timeout only counts when enabled; rvalid in the same cycle wins over it.
    assign timeout_s = TO_EN && (to_cnt_r == TO_LIM);
    assign done_s    = (state_r == WAIT) && (bus.mem_rvalid_i || timeout_s);
    assign keep_s    = bus.lock_i[sel_r] && bus.req_i[sel_r] && (lock_cnt_r < LOCK_LIM);

    // State and sequencing registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            sel_r      <= 2'd0;
            ptr_r      <= 2'd0;
            lock_cnt_r <= 4'd0;
            to_cnt_r   <= 8'd0;
        end else begin
            state_r    <= state_s;
            sel_r      <= sel_s;
            ptr_r      <= ptr_s;
            lock_cnt_r <= lock_cnt_s;
            to_cnt_r   <= to_cnt_s;
        end
    end

    // Next-state: arbitration, acceptance, completion, lock continuation and release.
    always_comb begin
        state_s    = state_r;
        sel_s      = sel_r;
        ptr_s      = ptr_r;
        lock_cnt_s = lock_cnt_r;
        to_cnt_s   = to_cnt_r;
        pick_s     = 3'b000;
        case (state_r)
            IDLE: begin
                pick_s = rr_pick(bus.req_i, ptr_r);
                if (pick_s[2]) begin
                    state_s    = ISSUE;
                    sel_s      = pick_s[1:0];
                    lock_cnt_s = 4'd1;
                end else begin
                    state_s    = IDLE;
                end
            end
            ISSUE: begin
                if (bus.mem_ready_i) begin
                    state_s  = WAIT;
                    to_cnt_s = 8'd0;
                end else begin
                    state_s  = ISSUE;
                end
            end
            WAIT: begin
                if (done_s) begin
                    if (keep_s) begin
                        state_s    = ISSUE;
                        lock_cnt_s = lock_cnt_r + 4'd1;
                    end else begin
                        // Release: the owner goes to the back of the rotation and
                        // is masked so the next owner is issued with no bubble.
                        ptr_s  = sel_r + 2'd1;
                        pick_s = rr_pick(bus.req_i & ~onehot(sel_r), sel_r + 2'd1);
                        if (pick_s[2]) begin
                            state_s    = ISSUE;
                            sel_s      = pick_s[1:0];
                            lock_cnt_s = 4'd1;
                        end else begin
                            state_s    = IDLE;
                            sel_s      = 2'd0;
                        end
                    end
                end else begin
                    to_cnt_s = to_cnt_r + 8'd1;
                end
            end
            default: begin
                state_s = IDLE;
                sel_s   = 2'd0;
            end
        endcase
    end

    // Outputs decoded from the registered state; the completion pulse is raised
    // in the completion cycle itself so the owner can drop its request in time.
    always_comb begin
        gnt_s       = 4'b0000;
        mem_valid_s = 1'b0;
        ack_s       = 4'b0000;
        err_s       = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            IDLE: begin
                busy_s = 1'b0;
            end
            ISSUE: begin
                gnt_s       = onehot(sel_r);
                mem_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            WAIT: begin
                gnt_s  = onehot(sel_r);
                busy_s = 1'b1;
                if (done_s) begin
                    ack_s = onehot(sel_r);
                    err_s = !bus.mem_rvalid_i;
                end else begin
                    ack_s = 4'b0000;
                    err_s = 1'b0;
                end
            end
            default: begin
                gnt_s = 4'b0000;
            end
        endcase
    end

    assign bus.gnt_o       = gnt_s;
    assign bus.sel_o       = sel_r;
    assign bus.mem_valid_o = mem_valid_s;
    assign bus.ack_o       = ack_s;
    assign bus.err_o       = err_s;
    assign bus.busy_o      = busy_s;

endmodule
